// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side types and constants: XLEN, instruction size, NOP encoding, fetch FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] RV_NOP = {25'b0, OPC_OP_IMM};

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } ifid_t;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory port, redirect input, IF/ID handshake and status.
// Latency: n/a (wiring only).
// Backpressure: out_ready from decode stalls the IF/ID register.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic            fault;
    logic [XLEN-1:0] fault_pc;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_illegal,
        output fault,
        output fault_pc,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_illegal,
        input  fault,
        input  fault_pc,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID output register: holds one fetched instruction, flush fills with NOP and clears valid.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: holds contents while out_vld & ~out_rdy; adv tells upstream a new word can load.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_vld,
    input  ifid_t in_dat,
    input  logic  flush,
    input  logic  out_rdy,
    output logic  adv,
    output logic  hs,
    output logic  out_vld,
    output ifid_t out_dat
);

    logic  vld_q, vld_d;
    ifid_t dat_q, dat_d;
    ifid_t bubble;

    always_comb begin
        bubble.instr   = NOP_INSTR;
        bubble.pc      = '0;
        bubble.illegal = 1'b0;
    end

    assign adv = ~vld_q | out_rdy;
    assign hs  = vld_q & out_rdy;

    // Flush wins over a load; a concurrent handshake has already consumed the held word.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = 1'b0;
            dat_d = bubble;
        end else if (in_vld && adv) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= bubble;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, combinational imem address, redirect/flush and sticky misalign fault.
// Latency: 1 cycle pc -> out_valid; 1 bubble per redirect; 1 instr/cycle sustained.
// Backpressure: out_ready low holds pc and the IF/ID register; redirects override the stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    logic  in_vld;
    logic  flush;
    logic  adv;
    logic  hs;
    logic  out_vld;
    ifid_t in_dat;
    ifid_t out_dat;
    logic  redirect_bad;

    assign redirect_bad = misaligned(bus.redirect_pc[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == FS_RUN && bus.redirect_valid && redirect_bad) begin
            state_d = FS_FAULT;
        end
    end

    // In FAULT nothing is fetched and redirects are ignored; pc and fault_pc freeze.
    always_comb begin
        in_vld     = 1'b0;
        flush      = 1'b0;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        if (state_q == FS_RUN) begin
            if (bus.redirect_valid) begin
                flush = 1'b1;
                if (redirect_bad) begin
                    fault_pc_d = bus.redirect_pc;
                end else begin
                    pc_d = bus.redirect_pc;
                end
            end else begin
                in_vld = 1'b1;
                if (adv) begin
                    pc_d = pc_next(pc_q);
                end
            end
        end
        fetch_count_d = fetch_count_q + {{(XLEN-1){1'b0}}, hs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        in_dat.instr   = bus.imem_rdata;
        in_dat.pc      = pc_q;
        in_dat.illegal = (bus.imem_rdata == '0);
    end

    fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .flush   (flush),
        .out_rdy (bus.out_ready),
        .adv     (adv),
        .hs      (hs),
        .out_vld (out_vld),
        .out_dat (out_dat)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_vld;
    assign bus.out_instr   = out_dat.instr;
    assign bus.out_pc      = out_dat.pc;
    assign bus.out_illegal = out_dat.illegal;
    assign bus.fault       = (state_q == FS_FAULT);
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: stream-level reference model of what decode receives.
// Per-cycle state snapshots and accepted-instruction records are queued and checked by a monitor.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory returns 0 (unsupported opcode) at any address with low byte 0x10.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[7:0] == 8'h10) return 32'h0;
        return {a[31:2], 2'b11};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic        flt;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } snap_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ill;
    } xact_t;

    snap_t snap_q[$];
    xact_t xact_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;

    // Reference model: next pc decode should receive, whether something is held, fault state.
    bit          m_vld;
    bit          m_flt;
    logic [31:0] m_next;
    logic [31:0] m_faddr;
    logic [31:0] m_fpc;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_addr();
        if (m_flt) return m_faddr;
        return m_next + (m_vld ? 32'd4 : 32'd0);
    endfunction

    always @(negedge clk) begin : monitor
        snap_t s;
        xact_t x;
        if (mon_en) begin
            if (snap_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL snap_underflow actual=empty required=entry");
            end else begin
                s = snap_q.pop_front();
                chk("out_valid",   {31'b0, bus.out_valid}, {31'b0, s.vld});
                chk("imem_addr",   bus.imem_addr,          s.addr);
                chk("fault",       {31'b0, bus.fault},     {31'b0, s.flt});
                chk("fault_pc",    bus.fault_pc,           s.fpc);
                chk("fetch_count", bus.fetch_count,        s.cnt);
                if (!s.vld) begin
                    chk("idle_instr",   bus.out_instr,            NOP);
                    chk("idle_pc",      bus.out_pc,               32'h0);
                    chk("idle_illegal", {31'b0, bus.out_illegal}, 32'h0);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (xact_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL xact_underflow actual=handshake@%h required=none", bus.out_pc);
                end else begin
                    x = xact_q.pop_front();
                    chk("out_pc",      bus.out_pc,               x.pc);
                    chk("out_instr",   bus.out_instr,            x.instr);
                    chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, x.ill});
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        #2;
        chk("rst_out_valid",   {31'b0, bus.out_valid},   32'h0);
        chk("rst_out_instr",   bus.out_instr,            NOP);
        chk("rst_out_pc",      bus.out_pc,               32'h0);
        chk("rst_out_illegal", {31'b0, bus.out_illegal}, 32'h0);
        chk("rst_fault",       {31'b0, bus.fault},       32'h0);
        chk("rst_fault_pc",    bus.fault_pc,             32'h0);
        chk("rst_fetch_count", bus.fetch_count,          32'h0);
        chk("rst_imem_addr",   bus.imem_addr,            RST_PC);
        chk("rst_xact_left",   32'(xact_q.size()),       32'h0);
        snap_q.delete();
        xact_q.delete();
        m_vld   = 1'b0;
        m_flt   = 1'b0;
        m_next  = RST_PC;
        m_faddr = 32'h0;
        m_fpc   = 32'h0;
        m_cnt   = 32'h0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = 32'h0000_0100;
            1:       t = 32'hFFFF_FFF0;
            2:       t = {24'h0, 6'($urandom_range(63)), 2'b00};
            default: t = $urandom() & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    task automatic run_phase(input int ncyc, input int rdy_pct, input int rd_pct, input int mis_pct);
        snap_t       s;
        xact_t       x;
        bit          rdy;
        bit          rv;
        bit          hs;
        logic [31:0] tgt;
        logic [31:0] a_now;
        for (int c = 0; c < ncyc; c++) begin
            s.vld  = m_vld;
            s.addr = model_addr();
            s.flt  = m_flt;
            s.fpc  = m_fpc;
            s.cnt  = m_cnt;
            snap_q.push_back(s);

            rdy = ($urandom_range(99) < rdy_pct);
            rv  = ($urandom_range(99) < rd_pct);
            tgt = pick_target();
            if (rv && ($urandom_range(99) < mis_pct)) tgt[1:0] = 2'($urandom_range(1, 3));
            bus.out_ready      = rdy;
            bus.redirect_valid = rv;
            bus.redirect_pc    = rv ? tgt : $urandom();

            if (!m_flt) begin
                a_now = model_addr();
                hs    = m_vld && rdy;
                if (hs) begin
                    x.pc    = m_next;
                    x.instr = mem_word(m_next);
                    x.ill   = (mem_word(m_next) == 32'h0);
                    xact_q.push_back(x);
                    m_next = m_next + 32'd4;
                    m_cnt  = m_cnt + 32'd1;
                end
                if (rv) begin
                    if (tgt[1:0] != 2'b00) begin
                        m_flt   = 1'b1;
                        m_fpc   = tgt;
                        m_faddr = a_now;
                    end else begin
                        m_next = tgt;
                    end
                    m_vld = 1'b0;
                end else begin
                    m_vld = 1'b1;
                end
            end

            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        do_reset();
        run_phase(8, 100, 0, 0);
        do_reset();
        run_phase(400, 50, 10, 0);
        do_reset();
        run_phase(400, 80, 15, 5);
        do_reset();
        run_phase(300, 30, 30, 20);
        do_reset();
        run_phase(300, 90, 5, 2);

        @(negedge clk);
        mon_en = 1'b0;
        chk("end_xact_left", 32'(xact_q.size()), 32'h0);
        chk("end_snap_left", 32'(snap_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
